sum_uart_tx: RTL and testbench

//   Downstream consumer of the 8-bit operand sum produced by the adder stage.

---
 rtl/sum_uart_tx.sv | 140 ++++++++++++++
 tb/tb_sum_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_uart_tx.sv
// Buffers adder sums in a small FIFO and serializes each one as an 8N1 UART frame (LSB first).
// Latency: 1 cycle from push into an empty FIFO to the start bit. Backpressure: in_ready drops while the FIFO is full.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            bit_end;

  assign in_ready = (fifo_count != (AW+1)'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud == BW'(CLKS_PER_BIT - 1));

  // Pop decisions use the registered count, so a byte pushed this edge is seen next edge.
  always_comb begin
    pop = 1'b0;
    if (fifo_count != '0) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == STOP && bit_end)
        pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // tx takes the next bit directly so it lines up with the shift.
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Scoreboard bench for sum_uart_tx: accepted bytes are queued and checked against frames decoded from tx.
module tb_sum_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int push_cyc;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder: samples tx mid-bit on the falling edge.
  logic       in_frame = 1'b0;
  int         pos, low_cnt, start_cyc, frames = 0;
  logic [9:0] fr;
  int         busy_run = 0, last_busy = 0, max_cnt = 0;
  logic [7:0] e;

  always @(negedge clk) begin
    if (fifo_count > max_cnt) max_cnt = fifo_count;
    if (busy) busy_run++;
    else if (busy_run > 0) begin last_busy = busy_run; busy_run = 0; end
    if (rst) begin
      in_frame = 1'b0;
      busy_run = 0;
    end else begin
      if (!in_frame && tx == 1'b0) begin
        in_frame  = 1'b1;
        pos       = 0;
        low_cnt   = 0;
        start_cyc = cyc;
      end
      if (in_frame) begin
        if (!tx) low_cnt++;
        if (pos % CPB == CPB / 2) fr[pos / CPB] = tx;
        if (pos == 10 * CPB - 1) begin
          in_frame = 1'b0;
          frames++;
          if (sb.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("frame_bits", int'(fr), int'({1'b1, e, 1'b0}));
            chk("low_cycles", low_cnt, CPB * (9 - $countones(e)));
          end
        end
        pos++;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int   guard = 0;
    logic acc;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      if (acc) sb.push_back(b);
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 500);
    if (!acc) chk("push_timeout", 0, 1);
    push_cyc = cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || busy || in_frame) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_timeout", int'(guard < 3000), 1);
    wait_cycles(3);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    wait_cycles(3);
    rst = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", in_ready, 1);

    // Single frame: latency and busy duration.
    push(8'hA5);
    in_valid = 1'b0;
    n = push_cyc;
    wait_cycles(3);
    chk("t1_latency", start_cyc - n, 1);
    drain();
    chk("t1_busy_len", last_busy, 10 * CPB);

    // Burst with valid held: FIFO fills, extra push while full is ignored.
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("t2_full_count", fifo_count, DEPTH);
    chk("t2_full_ready", in_ready, 0);
    in_data = 8'h77;
    wait_cycles(2);
    chk("t2_full_hold", fifo_count, DEPTH);
    in_valid = 1'b0;
    drain();
    chk("t2_busy_len", last_busy, 50 * CPB);

    // Push on the same edge as a STOP-end pop with two entries buffered.
    push(8'h10);
    n = push_cyc;
    push(8'h20);
    push(8'h30);
    in_valid = 1'b0;
    wait_until(n + 10 * CPB);
    chk("t3_pre_count", fifo_count, 2);
    push(8'h40);
    in_valid = 1'b0;
    chk("t3_same_edge", push_cyc, n + 10 * CPB + 1);
    chk("t3_count", fifo_count, 2);
    drain();

    // Reset during DATA bit 3 of 0xFF with two bytes queued.
    n = frames;
    push(8'hFF);
    push_cyc = push_cyc;
    begin
      int n0 = push_cyc;
      push(8'h11);
      push(8'h22);
      in_valid = 1'b0;
      chk("t4_count", fifo_count, 2);
      wait_until(n0 + 1 + CPB + 3 * CPB + 1);
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_tx", tx, 1);
    chk("t4_busy", busy, 0);
    chk("t4_count_clr", fifo_count, 0);
    wait_cycles(100);
    chk("t4_no_frames", frames, n);
    chk("t4_line_idle", int'(in_frame), 0);

    // Extreme data patterns.
    push(8'h00);
    in_valid = 1'b0;
    wait_cycles(59);
    push(8'hFF);
    in_valid = 1'b0;
    drain();

    // Nine spaced bytes walk the pointers around the buffer twice.
    max_cnt = 0;
    n = frames;
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h31 + i * 8'h1D));
      in_valid = 1'b0;
      wait_cycles(10 * CPB + 4);
    end
    drain();
    chk("t6_frames", frames - n, 9);
    chk("t6_max_count", max_cnt, 1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
